// File: rtl/wb_to_ibex_if.sv
// Bus bundle for the Wishbone-to-Ibex bridge: Wishbone pipelined slave side plus
// the Ibex-style req/gnt/rvalid request side. The slave modport is the bridge's view.
interface wb_to_ibex_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Wishbone side
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_we_i;
    logic [AW-1:0]   wb_addr_i;
    logic [DW-1:0]   wb_data_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_stall_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [DW-1:0]   wb_data_o;

    // Ibex-style request side
    logic            req_o;
    logic            gnt_i;
    logic [AW-1:0]   addr_o;
    logic            we_o;
    logic [DW/8-1:0] be_o;
    logic [DW-1:0]   wdata_o;
    logic            rvalid_i;
    logic            err_i;
    logic [DW-1:0]   rdata_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        output wb_stall_o, wb_ack_o, wb_err_o, wb_data_o,
        output req_o, addr_o, we_o, be_o, wdata_o,
        input  gnt_i, rvalid_i, err_i, rdata_i
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        input  wb_stall_o, wb_ack_o, wb_err_o, wb_data_o,
        input  req_o, addr_o, we_o, be_o, wdata_o,
        output gnt_i, rvalid_i, err_i, rdata_i
    );
endinterface

// File: rtl/wb_to_ibex.sv
// Wishbone B4 pipelined slave to Ibex-style req/gnt/rvalid bridge with a one-entry
// command register, outstanding-request tracking and draining of abandoned cycles.
module wb_to_ibex #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_to_ibex_if.slave    bus
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t          state_reg;
    logic            pend_reg;
    logic [CW-1:0]   cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic            we_reg;
    logic [BW-1:0]   be_reg;
    logic [DW-1:0]   wdata_reg;
    logic            ack_reg;
    logic            err_reg;
    logic [DW-1:0]   rdata_reg;

    logic            drain;
    logic [CW-1:0]   total;
    logic            stall;
    logic            accept;
    logic            grant;
    logic            rsp_fire;
    logic            rsp_fwd;
    logic            pend_next;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   total_next;
    logic [BW-1:0]   be_cmd;

    // Reads always fetch the whole word; writes honour the byte selects.
    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_be
            assign be_cmd[gi] = bus.wb_sel_i[gi] | ~bus.wb_we_i;
        end
    endgenerate

    assign drain      = (state_reg == DRAIN);
    assign total      = cnt_reg + CW'(pend_reg);
    assign stall      = drain | ~bus.wb_cyc_i | (pend_reg & ~bus.gnt_i) | (total >= MAX_CNT);
    assign accept     = bus.wb_cyc_i & bus.wb_stb_i & ~stall;
    assign grant      = pend_reg & bus.gnt_i;
    // A stray rvalid with nothing granted is dropped rather than corrupting the count.
    assign rsp_fire   = bus.rvalid_i & (cnt_reg != '0);
    assign rsp_fwd    = rsp_fire & ~drain & bus.wb_cyc_i;
    assign pend_next  = accept | (pend_reg & ~grant);
    assign cnt_next   = cnt_reg + CW'(grant) - CW'(rsp_fire);
    assign total_next = cnt_next + CW'(pend_next);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            pend_reg  <= 1'b0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            cnt_reg  <= cnt_next;
            // Only a new accept reloads the command, so it holds steady while ungranted.
            if (accept) begin
                addr_reg  <= bus.wb_addr_i;
                we_reg    <= bus.wb_we_i;
                be_reg    <= be_cmd;
                wdata_reg <= bus.wb_data_i;
            end

            ack_reg <= rsp_fwd & ~bus.err_i;
            err_reg <= rsp_fwd & bus.err_i;
            if (rsp_fwd) begin
                rdata_reg <= bus.rdata_i;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (total_next == '0) begin
                        state_reg <= IDLE;
                    end else if (!bus.wb_cyc_i) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (total_next == '0) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.wb_stall_o = stall;
    assign bus.wb_ack_o   = ack_reg;
    assign bus.wb_err_o   = err_reg;
    assign bus.wb_data_o  = rdata_reg;
    assign bus.req_o      = pend_reg;
    assign bus.addr_o     = addr_reg;
    assign bus.we_o       = we_reg;
    assign bus.be_o       = be_reg;
    assign bus.wdata_o    = wdata_reg;

    // The downstream port must never answer something that was not granted.
    a_rvalid_has_cmd: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.rvalid_i |-> (cnt_reg != '0));

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (pend_reg & ~bus.gnt_i) |=> (pend_reg && $stable(addr_reg) && $stable(we_reg)
                                     && $stable(be_reg) && $stable(wdata_reg)));
endmodule

// File: tb/tb_wb_to_ibex.sv
// Scoreboard bench for wb_to_ibex: expected responses are queued at accept time and
// popped when the bridge acks/errs; a small downstream model answers granted commands.
module tb_wb_to_ibex;
    logic clk;
    logic rst;

    wb_to_ibex_if #(.AW(32), .DW(32)) bus ();

    wb_to_ibex #(.AW(32), .DW(32), .MAX_OUTSTANDING(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] dq[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          acc_cnt  = 0;
    int          rsp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp_v);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Downstream answer for the oldest granted command, one cycle of rvalid.
    task automatic respond;
        logic [31:0] a;
        if (dq.size() == 0) begin
            check("resp_without_grant", 32'd1, 32'd0);
            return;
        end
        a = dq.pop_front();
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = data_for(a);
        bus.err_i    = a[12];
        tick;
        bus.rvalid_i = 1'b0;
        bus.err_i    = 1'b0;
    endtask

    // Monitor: record grants and accepts, check every response against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_o && bus.gnt_i) dq.push_back(bus.addr_o);
            if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_stall_o) begin
                exp_q.push_back({bus.wb_addr_i[12], data_for(bus.wb_addr_i)});
                acc_cnt++;
            end
            if (bus.wb_ack_o || bus.wb_err_o) begin
                rsp_cnt++;
                $display("txn rsp ack=%0b err=%0b data=%h", bus.wb_ack_o, bus.wb_err_o, bus.wb_data_o);
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", 32'(bus.wb_err_o), 32'(mon_e.err));
                    check("rsp_ack", 32'(bus.wb_ack_o), 32'(!mon_e.err));
                    check("rsp_data", bus.wb_data_o, mon_e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int rb;
        logic [31:0] a;

        rst = 1'b1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_addr_i = '0;  bus.wb_data_i = '0;  bus.wb_sel_i = '0;
        bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.err_i = 1'b0; bus.rdata_i = '0;
        repeat (3) tick;
        @(negedge clk);
        check("rst_req", 32'(bus.req_o), 0);
        check("rst_ack", 32'(bus.wb_ack_o), 0);
        check("rst_err", 32'(bus.wb_err_o), 0);
        check("rst_data", bus.wb_data_o, 0);
        check("rst_addr", bus.addr_o, 0);
        check("rst_stall", 32'(bus.wb_stall_o), 1);
        tick;
        rst = 1'b0;
        tick;

        // Single read, grant in the same cycle as req, rvalid two cycles later.
        bus.gnt_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        bus.wb_we_i = 1'b0; bus.wb_addr_i = 32'h100; bus.wb_sel_i = 4'hF;
        @(negedge clk);
        check("req_not_early", 32'(bus.req_o), 0);
        tick;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        check("req_after_stb", 32'(bus.req_o), 1);
        check("rd1_addr", bus.addr_o, 32'h100);
        tick;
        tick;
        a = dq.pop_front();
        bus.rvalid_i = 1'b1; bus.rdata_i = data_for(a); bus.err_i = a[12];
        @(negedge clk);
        check("ack_not_early", 32'(bus.wb_ack_o), 0);
        tick;
        bus.rvalid_i = 1'b0;
        @(negedge clk);
        check("ack_latency", 32'(bus.wb_ack_o), 1);
        check("ack_data", bus.wb_data_o, 32'hDEADBEEF);
        tick;
        @(negedge clk);
        check("ack_pulse", 32'(bus.wb_ack_o), 0);
        tick;

        // Write held ungranted for 3 cycles, then a read queued behind it.
        bus.gnt_i = 1'b0; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_addr_i = 32'h204; bus.wb_data_i = 32'hCAFE0001; bus.wb_sel_i = 4'b0011;
        tick;
        bus.wb_we_i = 1'b0; bus.wb_addr_i = 32'h308; bus.wb_data_i = 32'h11112222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_stall", 32'(bus.wb_stall_o), 1);
            check("hold_req", 32'(bus.req_o), 1);
            check("hold_addr", bus.addr_o, 32'h204);
            check("hold_wdata", bus.wdata_o, 32'hCAFE0001);
            check("wr_be", 32'(bus.be_o), 32'h3);
            check("wr_we", 32'(bus.we_o), 1);
            tick;
        end
        bus.gnt_i = 1'b1;
        @(negedge clk);
        check("gnt_unstall", 32'(bus.wb_stall_o), 0);
        tick;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        check("rd_be", 32'(bus.be_o), 32'hF);
        check("rd_we", 32'(bus.we_o), 0);
        check("rd_addr", bus.addr_o, 32'h308);
        tick;
        respond;
        respond;
        tick;
        tick;

        // Six back-to-back reads with rvalid withheld: only four fit.
        base = acc_cnt;
        rb = rsp_cnt;
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        for (int c = 0; c < 8; c++) begin
            bus.wb_addr_i = 32'h400 + 32'(4 * (acc_cnt - base));
            tick;
        end
        bus.wb_addr_i = 32'h400 + 32'(4 * (acc_cnt - base));
        @(negedge clk);
        check("max_out_accepts", 32'(acc_cnt - base), 4);
        check("max_out_stall", 32'(bus.wb_stall_o), 1);
        tick;
        for (int c = 0; c < 60; c++) begin
            if (rsp_cnt - rb >= 6) break;
            if (acc_cnt - base >= 6) bus.wb_stb_i = 1'b0;
            else bus.wb_addr_i = 32'h400 + 32'(4 * (acc_cnt - base));
            if (dq.size() > 0) begin
                a = dq.pop_front();
                bus.rvalid_i = 1'b1; bus.rdata_i = data_for(a); bus.err_i = a[12];
            end else begin
                bus.rvalid_i = 1'b0;
            end
            tick;
        end
        bus.rvalid_i = 1'b0; bus.wb_stb_i = 1'b0;
        check("max_out_total_acc", 32'(acc_cnt - base), 6);
        check("max_out_total_rsp", 32'(rsp_cnt - rb), 6);
        tick;

        // Abandon a cycle with three in flight; a new cycle waits for the drain.
        base = acc_cnt;
        bus.wb_stb_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (acc_cnt - base >= 3) break;
            bus.wb_addr_i = 32'h600 + 32'(4 * (acc_cnt - base));
            tick;
        end
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        exp_q.delete();
        repeat (3) tick;
        check("drain_inflight", 32'(dq.size()), 3);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h700;
        for (int k = 0; k < 3; k++) begin
            a = dq.pop_front();
            bus.rvalid_i = 1'b1; bus.rdata_i = data_for(a); bus.err_i = a[12];
            @(negedge clk);
            check("drain_stall", 32'(bus.wb_stall_o), 1);
            check("drain_quiet", 32'(bus.wb_ack_o | bus.wb_err_o), 0);
            tick;
            bus.rvalid_i = 1'b0;
        end
        @(negedge clk);
        check("drain_quiet_last", 32'(bus.wb_ack_o | bus.wb_err_o), 0);
        check("drain_release", 32'(bus.wb_stall_o), 0);
        tick;
        bus.wb_stb_i = 1'b0;
        tick;
        respond;
        tick;

        // Downstream error.
        bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h1040;
        tick;
        bus.wb_stb_i = 1'b0;
        tick;
        respond;
        @(negedge clk);
        check("err_flag", 32'(bus.wb_err_o), 1);
        check("err_noack", 32'(bus.wb_ack_o), 0);
        tick;

        // Reset with two outstanding.
        bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h800;
        tick;
        bus.wb_addr_i = 32'h804;
        tick;
        bus.wb_stb_i = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        dq.delete();
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_req", 32'(bus.req_o), 0);
        check("rst2_ack", 32'(bus.wb_ack_o), 0);
        check("rst2_err", 32'(bus.wb_err_o), 0);
        check("rst2_data", bus.wb_data_o, 0);
        check("rst2_addr", bus.addr_o, 0);
        check("rst2_we", 32'(bus.we_o), 0);
        check("rst2_be", 32'(bus.be_o), 0);
        check("rst2_wdata", bus.wdata_o, 0);
        check("rst2_cnt", 32'(dut.cnt_reg), 0);
        tick;
        bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h900;
        tick;
        bus.wb_stb_i = 1'b0;
        tick;
        respond;
        bus.wb_cyc_i = 1'b0;
        repeat (2) tick;
        check("sb_empty", 32'(exp_q.size()), 0);
        check("dq_empty", 32'(dq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
